// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue unit: opcodes, instruction field layout, FSM encoding.
package alu_issue_pkg;
  localparam int INSTR_W  = 9;
  localparam int DATA_W   = 4;
  localparam int IDX_W    = 2;
  localparam int NUM_REGS = 4;

  localparam int SEL_LSB = 6;
  localparam int SEL_W   = 3;
  localparam int RS_LSB  = 4;
  localparam int RT_LSB  = 2;
  localparam int RD_LSB  = 0;

  localparam logic [2:0] SEL_SUB = 3'd0;
  localparam logic [2:0] SEL_ADD = 3'd1;
  localparam logic [2:0] SEL_OR  = 3'd2;
  localparam logic [2:0] SEL_AND = 3'd3;
  localparam logic [2:0] SEL_ROR = 3'd4;
  localparam logic [2:0] SEL_ROL = 3'd5;
  localparam logic [2:0] SEL_SLT = 3'd6;
  localparam logic [2:0] SEL_SEQ = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WB    = 2'd2;

  function automatic logic [SEL_W-1:0] instr_sel(input logic [INSTR_W-1:0] instr);
    return instr[SEL_LSB +: SEL_W];
  endfunction

  function automatic logic [IDX_W-1:0] instr_idx(input logic [INSTR_W-1:0] instr, input int lsb);
    return instr[lsb +: IDX_W];
  endfunction
endpackage

// File: rtl/issue_fifo.sv
// Circular instruction buffer; push ignored when full, pop ignored when empty.
// Same-cycle push and pop both take effect and leave the count unchanged.
module issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) mem_d[wr_ptr_q] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/alu_issue_unit.sv
// Buffers instructions and issues them to an external combinational ALU, one per two cycles.
// The writeback lands before the next issue, so dependent instructions need no forwarding.
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  in_instr,
  input  logic        ld_en,
  input  logic [1:0]  ld_addr,
  input  logic [3:0]  ld_data,
  output logic [3:0]  alu_rs,
  output logic [3:0]  alu_rt,
  output logic [2:0]  alu_sel,
  input  logic [3:0]  alu_rd,
  output logic        wb_valid,
  output logic [1:0]  wb_addr,
  output logic [3:0]  wb_data,
  output logic        busy,
  output logic [15:0] dbg_rf
);
  logic [INSTR_W-1:0]        head;
  logic                      fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [IDX_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign fifo_pop  = (state_q == ST_ISSUE);

  issue_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(INSTR_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_instr),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    addr_d   = addr_q;
    rf_d     = rf_q;
    if (ld_en) rf_d[ld_addr] = ld_data;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE: begin
        result_d = alu_rd;
        addr_d   = instr_idx(head, RD_LSB);
        state_d  = ST_WB;
      end
      ST_WB: begin
        // Applied after the direct load so the writeback wins a same-index collision.
        rf_d[addr_q] = result_q;
        state_d      = fifo_empty ? ST_IDLE : ST_ISSUE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      addr_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      addr_q   <= addr_d;
      rf_q     <= rf_d;
    end
  end

  assign alu_sel  = (state_q == ST_ISSUE) ? instr_sel(head) : '0;
  assign alu_rs   = (state_q == ST_ISSUE) ? rf_q[instr_idx(head, RS_LSB)] : '0;
  assign alu_rt   = (state_q == ST_ISSUE) ? rf_q[instr_idx(head, RT_LSB)] : '0;
  assign wb_valid = (state_q == ST_WB);
  assign wb_addr  = (state_q == ST_WB) ? addr_q : '0;
  assign wb_data  = (state_q == ST_WB) ? result_q : '0;
  assign busy     = (fifo_count != '0) || (state_q != ST_IDLE);
  assign dbg_rf   = {rf_q[3], rf_q[2], rf_q[1], rf_q[0]};
endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: behavioural Decode_And_Execute ALU plus an in-order architectural model.
module tb_alu_issue_unit;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [8:0]  in_instr;
  logic        ld_en;
  logic [1:0]  ld_addr;
  logic [3:0]  ld_data;
  logic [3:0]  alu_rs, alu_rt, alu_rd;
  logic [2:0]  alu_sel;
  logic        wb_valid;
  logic [1:0]  wb_addr;
  logic [3:0]  wb_data;
  logic        busy;
  logic [15:0] dbg_rf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [3:0] m_rf [4];
  logic [1:0] exp_addr [$];
  logic [3:0] exp_data [$];
  logic [1:0] wb_addr_q [$];
  logic [3:0] wb_data_q [$];
  int         wb_cyc_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Decode_And_Execute ALU stage; compare ops return a tagged flag in the low bit.
  function automatic logic [3:0] alu_f(input logic [2:0] sel, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] w;
    logic [3:0] r;
    w = {a, a};
    case (sel)
      SEL_SUB: r = a - b;
      SEL_ADD: r = a + b;
      SEL_OR:  r = a | b;
      SEL_AND: r = a & b;
      SEL_ROR: begin w = w >> b[1:0]; r = w[3:0]; end
      SEL_ROL: begin w = w << b[1:0]; r = w[7:4]; end
      SEL_SLT: r = {3'b101, (a < b)};
      default: r = {3'b111, (a == b)};
    endcase
    return r;
  endfunction

  assign alu_rd = alu_f(alu_sel, alu_rs, alu_rt);

  alu_issue_unit #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_sel(alu_sel), .alu_rd(alu_rd),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy), .dbg_rf(dbg_rf)
  );

  always @(negedge clk) begin
    if (wb_valid === 1'b1 && rst === 1'b0) begin
      wb_addr_q.push_back(wb_addr);
      wb_data_q.push_back(wb_data);
      wb_cyc_q.push_back(cyc);
    end
  end

  // Architectural effect of one instruction, applied in program order.
  function automatic void model_instr(input logic [8:0] ins);
    logic [3:0] res;
    res = alu_f(ins[8:6], m_rf[ins[5:4]], m_rf[ins[3:2]]);
    m_rf[ins[1:0]] = res;
    exp_addr.push_back(ins[1:0]);
    exp_data.push_back(res);
  endfunction

  function automatic logic [15:0] model_rf();
    return {m_rf[3], m_rf[2], m_rf[1], m_rf[0]};
  endfunction

  function automatic void clear_queues();
    exp_addr.delete(); exp_data.delete();
    wb_addr_q.delete(); wb_data_q.delete(); wb_cyc_q.delete();
  endfunction

  task automatic do_load(input logic [1:0] a, input logic [3:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    m_rf[a] = d;
  endtask

  task automatic push_instr(input logic [8:0] ins);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL push_timeout in_ready=%b required=1", in_ready);
    end
    in_valid = 1'b1; in_instr = ins;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL idle_timeout busy=%b required=0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (dbg_rf !== 16'h0) begin failures++; $display("FAIL reset_rf got=%h exp=0000", dbg_rf); end
    checks++; if ({wb_valid, wb_addr, wb_data, alu_sel, alu_rs, alu_rt} !== '0) begin
      failures++; $display("FAIL reset_outputs got wb=%b/%0d/%0d alu=%0d/%0d/%0d exp all 0",
                           wb_valid, wb_addr, wb_data, alu_sel, alu_rs, alu_rt);
    end
  endtask

  task automatic test_add();
    clear_queues();
    do_load(2'd1, 4'd3); do_load(2'd2, 4'd5);
    push_instr(9'b001_01_10_11);
    model_instr(9'b001_01_10_11);
    checks++; if (busy !== 1'b1 || alu_sel !== 3'd0) begin failures++; $display("FAIL add_idle busy=%b sel=%0d exp busy=1 sel=0", busy, alu_sel); end
    @(negedge clk);
    checks++; if (alu_sel !== 3'd1) begin failures++; $display("FAIL add_sel got=%0d exp=1", alu_sel); end
    checks++; if (alu_rs !== 4'd3 || alu_rt !== 4'd5) begin failures++; $display("FAIL add_operands got=%0d/%0d exp=3/5", alu_rs, alu_rt); end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL add_wb_early got=%b exp=0", wb_valid); end
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1 || wb_addr !== 2'd3 || wb_data !== 4'd8) begin
      failures++; $display("FAIL add_wb got=%b/%0d/%0d exp=1/3/8", wb_valid, wb_addr, wb_data);
    end
    checks++; if (alu_sel !== 3'd0 || alu_rs !== 4'd0) begin failures++; $display("FAIL add_alu_quiet got=%0d/%0d exp=0/0", alu_sel, alu_rs); end
    @(negedge clk);
    checks++; if (dbg_rf[15:12] !== 4'd8) begin failures++; $display("FAIL add_r3 got=%0d exp=8", dbg_rf[15:12]); end
    checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL add_done wb=%b busy=%b exp=0/0", wb_valid, busy); end
  endtask

  task automatic test_dependency();
    clear_queues();
    do_load(2'd1, 4'd3); do_load(2'd3, 4'd8);
    push_instr(9'b000_11_01_00); model_instr(9'b000_11_01_00);
    push_instr(9'b001_00_00_01); model_instr(9'b001_00_00_01);
    wait_idle();
    checks++; if (dbg_rf[3:0] !== 4'd5) begin failures++; $display("FAIL dep_r0 got=%0d exp=5", dbg_rf[3:0]); end
    checks++; if (dbg_rf[7:4] !== 4'd10) begin failures++; $display("FAIL dep_r1 got=%0d exp=10", dbg_rf[7:4]); end
    checks++; if (dbg_rf !== model_rf()) begin failures++; $display("FAIL dep_rf got=%h exp=%h", dbg_rf, model_rf()); end
  endtask

  task automatic test_compare();
    clear_queues();
    do_load(2'd0, 4'd2); do_load(2'd1, 4'd9);
    push_instr(9'b110_00_01_10); model_instr(9'b110_00_01_10);
    push_instr(9'b111_00_01_11); model_instr(9'b111_00_01_11);
    wait_idle();
    checks++;
    if (wb_data_q.size() != 2) begin
      failures++; $display("FAIL cmp_count got=%0d exp=2", wb_data_q.size());
    end else begin
      if (wb_data_q[0] !== 4'd11 || wb_addr_q[0] !== 2'd2) begin failures++; $display("FAIL cmp_slt got=%0d@r%0d exp=11@r2", wb_data_q[0], wb_addr_q[0]); end
      checks++;
      if (wb_data_q[1] !== 4'd14 || wb_addr_q[1] !== 2'd3) begin failures++; $display("FAIL cmp_seq got=%0d@r%0d exp=14@r3", wb_data_q[1], wb_addr_q[1]); end
    end
  endtask

  task automatic test_collision();
    int n = 0;
    clear_queues();
    push_instr(9'b111_01_01_10); model_instr(9'b111_01_01_10);
    while (wb_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n >= 20) begin
      failures++; $display("FAIL coll_wb_timeout wb_valid=%b exp=1", wb_valid);
    end else begin
      ld_en = 1'b1; ld_addr = 2'd2; ld_data = 4'd7;
      @(negedge clk);
      ld_en = 1'b0;
      checks++; if (dbg_rf[11:8] !== 4'd15) begin failures++; $display("FAIL coll_r2 got=%0d exp=15", dbg_rf[11:8]); end
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    logic [8:0] ins [6];
    clear_queues();
    for (int i = 0; i < 6; i++) begin
      ins[i] = 9'($urandom);
      model_instr(ins[i]);
    end
    for (int i = 0; i < 6; i++) push_instr(ins[i]);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full in_ready=%b exp=0", in_ready); end
    wait_idle();
    checks++;
    if (wb_data_q.size() != 6) begin
      failures++; $display("FAIL bp_count got=%0d exp=6", wb_data_q.size());
    end
    for (int i = 0; i < 6 && i < wb_data_q.size(); i++) begin
      checks++;
      if (wb_addr_q[i] !== exp_addr[i] || wb_data_q[i] !== exp_data[i]) begin
        failures++; $display("FAIL bp_order[%0d] got=%0d@r%0d exp=%0d@r%0d", i, wb_data_q[i], wb_addr_q[i], exp_data[i], exp_addr[i]);
      end
      if (i > 0) begin
        checks++;
        if (wb_cyc_q[i] - wb_cyc_q[i-1] != 2) begin failures++; $display("FAIL bp_spacing[%0d] got=%0d exp=2", i, wb_cyc_q[i] - wb_cyc_q[i-1]); end
      end
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 4; round++) begin
      int n_ins;
      clear_queues();
      for (int r = 0; r < 4; r++) do_load(2'(r), 4'($urandom));
      n_ins = $urandom_range(5, 9);
      for (int i = 0; i < n_ins; i++) begin
        logic [8:0] ins;
        ins = 9'($urandom);
        model_instr(ins);
        push_instr(ins);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle();
      checks++;
      if (wb_data_q.size() != exp_data.size()) begin
        failures++; $display("FAIL rand_count got=%0d exp=%0d", wb_data_q.size(), exp_data.size());
      end else begin
        for (int i = 0; i < exp_data.size(); i++) begin
          checks++;
          if (wb_addr_q[i] !== exp_addr[i] || wb_data_q[i] !== exp_data[i]) begin
            failures++; $display("FAIL rand_wb[%0d] got=%0d@r%0d exp=%0d@r%0d", i, wb_data_q[i], wb_addr_q[i], exp_data[i], exp_addr[i]);
          end
        end
      end
      checks++; if (dbg_rf !== model_rf()) begin failures++; $display("FAIL rand_rf got=%h exp=%h", dbg_rf, model_rf()); end
    end
  endtask

  task automatic test_reset_mid_wb();
    int n = 0;
    clear_queues();
    do_load(2'd1, 4'd3); do_load(2'd2, 4'd5);
    push_instr(9'b001_01_10_11);
    push_instr(9'b001_01_01_00);
    while (wb_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (n >= 20) begin failures++; $display("FAIL rst_wb_timeout wb_valid=%b exp=1", wb_valid); end
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    #1;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rst_wb_valid got=%b exp=0", wb_valid); end
    checks++; if (dbg_rf !== 16'h0) begin failures++; $display("FAIL rst_rf got=%h exp=0000", dbg_rf); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rst_flags in_ready=%b busy=%b exp=1/0", in_ready, busy); end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (dbg_rf !== 16'h0) begin failures++; $display("FAIL rst_no_write got=%h exp=0000", dbg_rf); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_flushed busy=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_dependency();
    test_compare();
    test_collision();
    test_backpressure();
    test_random();
    test_reset_mid_wb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving the number of instruction buffer entries (power of two).
REQ-002 SHALL have one clock, `clk`; reset is asynchronous and active-high, named `rst`.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  instruction offered.
REQ-006 in_ready  output  1  buffer can accept an instruction.
REQ-007 in_instr  input  9  fields: [8:6] sel, [5:4] rs_idx, [3:2] rt_idx, [1:0] rd_idx.
REQ-008 ld_en  input  1  direct register load strobe.
REQ-009 ld_addr  input  2  register index for the direct load.
REQ-010 ld_data  input  4  direct load value.
REQ-011 alu_rs  output  4  first operand driven to the Decode_And_Execute ALU stage.
REQ-012 alu_rt  output  4  second operand driven to the ALU stage.
REQ-013 alu_sel  output  3  operation select driven to the ALU stage.
REQ-014 alu_rd  input  4  combinational ALU result.
REQ-015 wb_valid  output  1  one-cycle writeback pulse.
REQ-016 wb_addr  output  2  writeback register index.
REQ-017 wb_data  output  4  writeback value.
REQ-018 busy  output  1  high when the FIFO is non-empty or state is not IDLE.
REQ-019 dbg_rf  output  16  register file contents, r3 in [15:12] down to r0 in [3:0].

Function
REQ-020 SHALL hold a 4x4-bit register file and a FIFO of FIFO_DEPTH 9-bit entries.
REQ-021 in_ready SHALL be !full, derived from the registered count; a push occurs when in_valid && in_ready.
REQ-022 The FSM SHALL have three states, IDLE, ISSUE and WB; IDLE->ISSUE when the FIFO is non-empty; ISSUE->WB always; WB->ISSUE if the FIFO is non-empty after the pop, else WB->IDLE.
REQ-023 In ISSUE: alu_sel = head.sel, alu_rs = rf[head.rs_idx], alu_rt = rf[head.rt_idx]; on the edge leaving ISSUE, result_q <= alu_rd, addr_q <= head.rd_idx, and the head is popped.
REQ-024 In WB: wb_valid = 1, wb_addr = addr_q, wb_data = result_q; rf[addr_q] <= result_q on the edge leaving WB.
REQ-025 Outside ISSUE, alu_rs, alu_rt and alu_sel SHALL be 0; outside WB, wb_valid, wb_addr and wb_data SHALL be 0.
REQ-026 Throughput SHALL be one instruction per 2 cycles, and instructions SHALL retire in FIFO order.
REQ-027 A dependent instruction SHALL read the updated value with no forwarding required, because the write lands before the next ISSUE.
REQ-028 ld_en SHALL write rf[ld_addr] = ld_data at the clock edge.
REQ-029 When ld_en and the WB write target the same index in the same cycle, the WB write SHALL win.
REQ-030 Pushes and pops in the same cycle SHALL both take effect, and the count SHALL be unchanged.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 A push while full SHALL be impossible, because in_ready = 0; the FIFO SHALL never overflow or pop while empty.

Reset
REQ-033 rst SHALL asynchronously clear the FIFO (empty, pointers 0), the register file (all 0), result_q, addr_q and all outputs, and SHALL set the state to IDLE.
REQ-034 After reset, in_ready SHALL be 1 and busy SHALL be 0.
REQ-035 Reset mid-ISSUE or mid-WB SHALL discard the in-flight instruction with no register write.

Structure
REQ-036 A shared package SHALL hold the SEL_* opcode constants (SUB=0, ADD=1, OR=2, AND=3, ROR=4, ROL=5, SLT=6, SEQ=7), the instruction field positions and widths, and the state encoding.
REQ-037 The FIFO SHALL be one sub-module, issue_fifo, parameterised by depth and width, with push/pop/full/empty/count ports.

Verification
REQ-038 Bench SHALL connect the Decode_And_Execute ALU stage to alu_rs/alu_rt/alu_sel/alu_rd for all scenarios.
REQ-039 Reset check: assert rst mid-WB -> wb_valid = 0, dbg_rf = 0, in_ready = 1, busy = 0, and no write lands.
REQ-040 Add: load r1 = 3, r2 = 5, push 9'b001_01_10_11 -> during ISSUE alu_sel = 1, alu_rs = 3, alu_rt = 5; next cycle wb_valid = 1, wb_addr = 3, wb_data = 8; then dbg_rf[15:12] = 8.
REQ-041 Dependency: with r1 = 3, r3 = 8, push back-to-back SUB r0 = r3 - r1 then ADD r1 = r0 + r0 -> r0 = 5, r1 = 10.
REQ-042 Backpressure: push 6 instructions on consecutive cycles -> in_ready falls to 0 at count 4; all 6 retire in order with wb_valid every second cycle.
REQ-043 Collision: ld_en to r2 with value 7 in the same cycle as a WB to r2 with value 15 (SEQ, equal operands) -> r2 = 15.
REQ-044 Compare ops: with r0 = 2, r1 = 9, push SLT r2 = r0 < r1 -> wb_data = 11; then push SEQ r3 = r0 == r1 -> wb_data = 14.
